// File: rtl/mod113_serial_reducer_if.sv
// Operand and residue valid/ready handshakes for mod113_serial_reducer.
// The master side drives operands and consumes residues; the reducer is the slave.
interface mod113_serial_reducer_if #(
  parameter int unsigned IN_W = 54
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_res;
  logic            busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_res, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_res, busy
  );
endinterface

// File: rtl/mod113_serial_reducer.sv
// Serial mod-MOD reducer: Horner's rule over 6-bit chunks, MS chunk first, one chunk per clock.
// Define MOD113_SKIP_ZERO_CHUNKS_EN to start at the highest non-zero chunk.
module mod113_serial_reducer #(
  parameter int unsigned IN_W = 54,
  parameter int unsigned MOD  = 113
) (
  input logic                 clk,
  input logic                 rst,
  mod113_serial_reducer_if.slave bus
);
  localparam int unsigned NCHUNK = (IN_W + 5) / 6;
  localparam int unsigned OP_W   = NCHUNK * 6;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [OP_W-1:0]  r_op;
  logic [6:0]       r_acc;
  logic [IDX_W-1:0] r_idx;
  logic [6:0]       r_res;

  logic [OP_W-1:0]  w_op_ext;
  logic [5:0]       w_chunk;
  logic [12:0]      w_sum;
  logic [6:0]       w_acc_next;
  logic [IDX_W-1:0] w_start_idx;

  assign w_op_ext = OP_W'(bus.in_data);
  assign w_chunk  = r_op[6*r_idx +: 6];

  // 13 bits covers (MOD-1)*64+63 for any MOD up to 127, so the reduction is exact.
  assign w_sum      = {r_acc, 6'b0} + {7'b0, w_chunk};
  assign w_acc_next = 7'(w_sum % 13'(MOD));

`ifdef MOD113_SKIP_ZERO_CHUNKS_EN
  always_comb begin
    w_start_idx = '0;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (w_op_ext[6*i +: 6] != 6'd0) w_start_idx = IDX_W'(i);
    end
  end
`else
  always_comb begin
    w_start_idx = IDX_W'(NCHUNK - 1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_op    <= w_op_ext;
            r_acc   <= '0;
            r_idx   <= w_start_idx;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_next;
          if (r_idx == '0) begin
            r_res   <= w_acc_next;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign bus.out_res   = r_res;
endmodule
